// File: rtl/bram_debug_pkg.sv
// rtl/bram_debug_pkg.sv - shared encodings and defaults for the BRAM debug sequencer
// DBG_ZERO_FILL_EN adds the FILL state to the state encoding.
package bram_debug_pkg;

    localparam int         BRAMWORDS_DEF  = 4096;
    localparam int         RST_CYCLES_DEF = 4;
    localparam logic [3:0] WE_ALL         = 4'b1111;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_RUN  = 2'd1,
        OP_DUMP = 2'd2,
        OP_NOP  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
`ifdef DBG_ZERO_FILL_EN
        ST_FILL      = 3'd2,
`endif
        ST_RST       = 3'd3,
        ST_RUN       = 3'd4,
        ST_DUMP_RD   = 3'd5,
        ST_DUMP_WAIT = 3'd6,
        ST_DUMP_OUT  = 3'd7
    } state_e;

endpackage

// File: rtl/bram_debug_ctrl.sv
// rtl/bram_debug_ctrl.sv - LOAD/RUN/DUMP sequencer owning the RV32Core BRAM debug ports and core reset
// DBG_ZERO_FILL_EN: after LOAD, zero the remaining words of the selected RAM.
module bram_debug_ctrl
    import bram_debug_pkg::*;
#(
    parameter int BRAMWORDS  = BRAMWORDS_DEF,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_sel,
    input  logic [12:0] cmd_len,
    input  logic [31:0] cmd_cycles,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic [31:0] dram_a2,
    output logic [31:0] dram_wd2,
    output logic [3:0]  dram_we2,
    input  logic [31:0] dram_rd2,
    output logic [31:0] iram_a2,
    output logic [31:0] iram_wd2,
    output logic [3:0]  iram_we2,
    input  logic [31:0] iram_rd2,
    output logic        core_rst,
    output logic        busy,
    output logic        done
);

    localparam int              CW       = $clog2(BRAMWORDS) + 1;
    localparam int              PAD      = 32 - CW - 2;
    localparam logic [CW-1:0]   WORDS_C  = CW'(BRAMWORDS);
    localparam logic [CW-1:0]   IDX_ONE  = CW'(1);
    localparam logic [31:0]     RST_LAST = 32'(RST_CYCLES - 1);

    state_e        r_state;
    state_e        w_next;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] w_idx_nxt;
    logic [CW-1:0] r_len;
    logic [CW-1:0] w_len_clamp;
    logic          r_sel;
    logic [31:0]   r_cycles;
    logic [31:0]   r_cnt;
    logic [31:0]   r_a2;
    logic [31:0]   r_wd2;
    logic [3:0]    r_we2;
    logic [31:0]   r_rd_data;
    logic          r_rd_last;
    logic          r_done;
    logic          r_busy;
    logic          r_core_rst;
    logic          w_cmd_ready;
    logic          w_wr_ready;
    logic          w_rd_valid;
    logic          w_cmd_hs;
    logic          w_wr_hs;
    logic          w_rd_hs;

    function automatic logic [31:0] f_addr(input logic [CW-1:0] idx);
        return {{PAD{1'b0}}, idx, 2'b00};
    endfunction

    assign w_cmd_hs    = cmd_valid & w_cmd_ready;
    assign w_wr_hs     = wr_valid & w_wr_ready;
    assign w_rd_hs     = w_rd_valid & rd_ready;
    assign w_len_clamp = (32'(cmd_len) > 32'(BRAMWORDS)) ? WORDS_C : CW'(cmd_len);

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_idx_nxt = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    w_idx_nxt = '0;
                    case (op_e'(cmd_op))
`ifdef DBG_ZERO_FILL_EN
                        OP_LOAD: w_next = ST_LOAD;
`else
                        OP_LOAD: w_next = (w_len_clamp == '0) ? ST_IDLE : ST_LOAD;
`endif
                        OP_RUN:  w_next = ST_RST;
                        OP_DUMP: w_next = (w_len_clamp == '0) ? ST_IDLE : ST_DUMP_RD;
                        default: w_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_wr_hs) w_idx_nxt = r_idx + IDX_ONE;
`ifdef DBG_ZERO_FILL_EN
                if (r_idx == r_len) w_next = ST_FILL;
`else
                if (r_idx == r_len) w_next = ST_IDLE;
`endif
            end
`ifdef DBG_ZERO_FILL_EN
            ST_FILL: begin
                if (r_idx == WORDS_C) w_next = ST_IDLE;
                else                  w_idx_nxt = r_idx + IDX_ONE;
            end
`endif
            ST_RST: begin
                if (r_cnt == RST_LAST) w_next = (r_cycles == 32'd0) ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == r_cycles - 32'd1) w_next = ST_IDLE;
            end
            ST_DUMP_RD:   w_next = ST_DUMP_WAIT;
            ST_DUMP_WAIT: w_next = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (w_rd_hs) begin
                    w_idx_nxt = r_idx + IDX_ONE;
                    w_next    = (r_idx == r_len - IDX_ONE) ? ST_IDLE : ST_DUMP_RD;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready = (r_state == ST_IDLE);
        w_wr_ready  = (r_state == ST_LOAD) && (r_idx < r_len);
        w_rd_valid  = (r_state == ST_DUMP_OUT);
    end

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            r_idx      <= '0;
            r_len      <= '0;
            r_sel      <= 1'b0;
            r_cycles   <= '0;
            r_cnt      <= '0;
            r_a2       <= '0;
            r_wd2      <= '0;
            r_we2      <= '0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_core_rst <= 1'b1;
        end else begin
            r_idx      <= w_idx_nxt;
            r_cnt      <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
            r_busy     <= (w_next != ST_IDLE);
            r_done     <= (w_next == ST_IDLE) && ((r_state != ST_IDLE) || w_cmd_hs);
            // Core runs only in RUN, so it never executes while the debug ports write.
            r_core_rst <= (w_next != ST_RUN);
            r_we2      <= '0;
            if (w_cmd_hs) begin
                r_sel    <= cmd_sel;
                r_len    <= w_len_clamp;
                r_cycles <= cmd_cycles;
            end
            if (r_state == ST_LOAD && w_wr_hs) begin
                r_a2  <= f_addr(r_idx);
                r_wd2 <= wr_data;
                r_we2 <= WE_ALL;
            end
`ifdef DBG_ZERO_FILL_EN
            if (r_state == ST_FILL && r_idx != WORDS_C) begin
                r_a2  <= f_addr(r_idx);
                r_wd2 <= '0;
                r_we2 <= WE_ALL;
            end
`endif
            // Address is registered on entry so it is on the port throughout DUMP_RD.
            if (w_next == ST_DUMP_RD && r_state != ST_DUMP_RD) r_a2 <= f_addr(w_idx_nxt);
            if (r_state == ST_DUMP_WAIT) begin
                r_rd_data <= r_sel ? iram_rd2 : dram_rd2;
                r_rd_last <= (r_idx == r_len - IDX_ONE);
            end else if (w_rd_hs) begin
                r_rd_last <= 1'b0;
            end
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign wr_ready  = w_wr_ready;
    assign rd_valid  = w_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_last   = r_rd_last;
    assign core_rst  = r_core_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dram_a2   = r_sel ? 32'd0 : r_a2;
    assign dram_wd2  = r_sel ? 32'd0 : r_wd2;
    assign dram_we2  = r_sel ? 4'd0  : r_we2;
    assign iram_a2   = r_sel ? r_a2  : 32'd0;
    assign iram_wd2  = r_sel ? r_wd2 : 32'd0;
    assign iram_we2  = r_sel ? r_we2 : 4'd0;

endmodule

// File: tb/tb_bram_debug_ctrl.sv
// tb/tb_bram_debug_ctrl.sv - directed self-checking bench for bram_debug_ctrl
// Define DBG_ZERO_FILL_EN to also exercise the zero-fill build.
module tb_bram_debug_ctrl;

`ifdef DBG_ZERO_FILL_EN
    localparam int LOAD_WRITES = 4096;
`else
    localparam int LOAD_WRITES = 3;
`endif

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_sel = 1'b0;
    logic [12:0] cmd_len = 13'd0;
    logic [31:0] cmd_cycles = 32'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = 32'd0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [31:0] dram_a2, dram_wd2, dram_rd2;
    logic [3:0]  dram_we2;
    logic [31:0] iram_a2, iram_wd2, iram_rd2;
    logic [3:0]  iram_we2;
    logic        core_rst, busy, done;

    logic [31:0] imem [0:4095];
    logic [31:0] dmem [0:4095];
    logic [31:0] prog [0:2];
    int total = 0;
    int bad = 0;

    always #5 CPU_CLK = ~CPU_CLK;

    bram_debug_ctrl dut (
        .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
        .cmd_len(cmd_len), .cmd_cycles(cmd_cycles),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .dram_a2(dram_a2), .dram_wd2(dram_wd2), .dram_we2(dram_we2), .dram_rd2(dram_rd2),
        .iram_a2(iram_a2), .iram_wd2(iram_wd2), .iram_we2(iram_we2), .iram_rd2(iram_rd2),
        .core_rst(core_rst), .busy(busy), .done(done)
    );

    // Behavioural BRAMs with one-cycle registered read.
    always @(posedge CPU_CLK) begin
        if (iram_we2 != 4'd0) imem[iram_a2[13:2]] <= iram_wd2;
        if (dram_we2 != 4'd0) dmem[dram_a2[13:2]] <= dram_wd2;
        iram_rd2 <= imem[iram_a2[13:2]];
        dram_rd2 <= dmem[dram_a2[13:2]];
    end

    task automatic step;
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic sel, input logic [12:0] len, input logic [31:0] cyc);
        cmd_op = op; cmd_sel = sel; cmd_len = len; cmd_cycles = cyc;
        cmd_valid = 1'b1;
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        CPU_RST = 1'b1;
        step;
        step;
        total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        total++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin bad++; $display("FAIL reset_rd_flags: got %b%b want 00", rd_valid, rd_last); end
        total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        total++; if ({iram_we2, dram_we2} !== 8'd0) begin bad++; $display("FAIL reset_we2: got %h want 0", {iram_we2, dram_we2}); end
        total++; if ({iram_a2, dram_a2, iram_wd2, dram_wd2} !== 128'd0) begin bad++; $display("FAIL reset_ports: got %h want 0", {iram_a2, dram_a2, iram_wd2, dram_wd2}); end
        CPU_RST = 1'b0;
        step;
    endtask

    task automatic test_load;
        int nw = 0, nd = 0, lastc = 0, gap = 0, derr = 0, sent = 0;
        logic hs;
        wr_valid = 1'b1;
        wr_data  = prog[0];
        issue(2'd0, 1'b1, 13'd3, 32'd0);
        for (int cyc = 0; cyc < 5000 && nd == 0; cyc++) begin
            if (iram_we2 === 4'hF) begin
                if (nw < 3) begin
                    total++; if (iram_a2 !== 32'(nw * 4)) begin bad++; $display("FAIL load_a2[%0d]: got %h want %h", nw, iram_a2, nw * 4); end
                    total++; if (iram_wd2 !== prog[nw]) begin bad++; $display("FAIL load_wd2[%0d]: got %h want %h", nw, iram_wd2, prog[nw]); end
                end
                if (nw > 0 && cyc != lastc + 1) gap++;
                lastc = cyc;
                nw++;
            end
            if (dram_we2 !== 4'd0) derr++;
            if (done === 1'b1) nd++;
            hs = wr_valid & wr_ready;
            step;
            if (hs) begin
                sent++;
                if (sent < 3) wr_data = prog[sent];
                else wr_valid = 1'b0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) nd++;
            step;
        end
        total++; if (nw != LOAD_WRITES) begin bad++; $display("FAIL load_count: got %0d want %0d", nw, LOAD_WRITES); end
        total++; if (gap != 0) begin bad++; $display("FAIL load_consecutive: got %0d gaps want 0", gap); end
        total++; if (derr != 0) begin bad++; $display("FAIL load_dram_idle: got %0d writes want 0", derr); end
        total++; if (nd != 1) begin bad++; $display("FAIL load_done: got %0d pulses want 1", nd); end
    endtask

    task automatic test_dump;
        int got = 0, stall = 0, nd = 0;
        logic hs;
        rd_ready = 1'b1;
        issue(2'd2, 1'b1, 13'd3, 32'd0);
        for (int cyc = 0; cyc < 100 && nd == 0; cyc++) begin
            hs = 1'b0;
            if (rd_valid === 1'b1 && got < 3) begin
                total++; if (rd_data !== prog[got]) begin bad++; $display("FAIL dump_data[%0d]: got %h want %h", got, rd_data, prog[got]); end
                total++; if (rd_last !== (got == 2)) begin bad++; $display("FAIL dump_last[%0d]: got %b want %b", got, rd_last, got == 2); end
                rd_ready = !(got == 1 && stall < 5);
                if (rd_ready) hs = 1'b1;
                else stall++;
            end
            if (done === 1'b1) nd++;
            step;
            if (hs) got++;
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done === 1'b1) nd++;
            step;
        end
        total++; if (got != 3) begin bad++; $display("FAIL dump_words: got %0d want 3", got); end
        total++; if (stall != 5) begin bad++; $display("FAIL dump_stall: got %0d want 5", stall); end
        total++; if (nd != 1) begin bad++; $display("FAIL dump_done: got %0d pulses want 1", nd); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL dump_idle_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_run;
        int pre = 0, low = 0, phase = 0, early = 0, late_low = 0;
        logic d_rise = 1'b0, b_rise = 1'b1;
        issue(2'd1, 1'b0, 13'd0, 32'd100);
        for (int i = 0; i < 112; i++) begin
            if (phase == 0) begin
                if (core_rst === 1'b1) pre++;
                else begin phase = 1; low = 1; end
            end else if (phase == 1) begin
                if (core_rst === 1'b0) low++;
                else begin phase = 2; d_rise = done; b_rise = busy; end
            end else if (core_rst !== 1'b1) late_low++;
            if (phase < 2 && done === 1'b1) early++;
            step;
        end
        total++; if (pre != 4) begin bad++; $display("FAIL run_rst_pulse: got %0d want 4", pre); end
        total++; if (low != 100) begin bad++; $display("FAIL run_cycles: got %0d want 100", low); end
        total++; if (phase != 2) begin bad++; $display("FAIL run_return: got phase %0d want 2", phase); end
        total++; if (d_rise !== 1'b1 || b_rise !== 1'b0) begin bad++; $display("FAIL run_done_at_idle: got done=%b busy=%b want 1 0", d_rise, b_rise); end
        total++; if (early != 0 || late_low != 0) begin bad++; $display("FAIL run_stray: got early=%0d late=%0d want 0 0", early, late_low); end
    endtask

    task automatic test_len0_nop;
        issue(2'd2, 1'b1, 13'd0, 32'd0);
        total++; if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL dump_len0: got done=%b busy=%b rd_valid=%b want 1 0 0", done, busy, rd_valid); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_in_done: got %b want 1", cmd_ready); end
        step;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_single: got %b want 0", done); end
        issue(2'd3, 1'b0, 13'd5, 32'd0);
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL nop_op: got done=%b busy=%b want 1 0", done, busy); end
`ifndef DBG_ZERO_FILL_EN
        issue(2'd0, 1'b0, 13'd0, 32'd0);
        total++; if (done !== 1'b1 || dram_we2 !== 4'd0) begin bad++; $display("FAIL load_len0: got done=%b we2=%h want 1 0", done, dram_we2); end
`endif
        step;
    endtask

    task automatic test_clamp;
        int nw = 0, nd = 0, ierr = 0, late = 0, sent = 0;
        logic [31:0] last_a2 = 32'd0;
        logic hs;
        wr_valid = 1'b1;
        wr_data  = 32'd0;
        issue(2'd0, 1'b0, 13'd5000, 32'd0);
        for (int cyc = 0; cyc < 4400 && nd == 0; cyc++) begin
            if (dram_we2 === 4'hF) begin nw++; last_a2 = dram_a2; end
            if (iram_we2 !== 4'd0) ierr++;
            if (sent >= 4096 && wr_ready !== 1'b0) late++;
            if (done === 1'b1) nd++;
            hs = wr_valid & wr_ready;
            step;
            if (hs) begin sent++; wr_data = 32'(sent); end
        end
        wr_valid = 1'b0;
        total++; if (nw != 4096) begin bad++; $display("FAIL clamp_count: got %0d want 4096", nw); end
        total++; if (last_a2 !== 32'h3FFC) begin bad++; $display("FAIL clamp_last_a2: got %h want 3ffc", last_a2); end
        total++; if (sent != 4096 || late != 0) begin bad++; $display("FAIL clamp_wr_ready: got sent=%0d late=%0d want 4096 0", sent, late); end
        total++; if (nd != 1 || ierr != 0) begin bad++; $display("FAIL clamp_done: got done=%0d iram=%0d want 1 0", nd, ierr); end
        total++; if (dmem[4095] !== 32'd4095) begin bad++; $display("FAIL clamp_last_word: got %h want fff", dmem[4095]); end
        step;
    endtask

    task automatic test_reset_mid;
        wr_valid = 1'b1;
        wr_data  = 32'hA0;
        issue(2'd0, 1'b0, 13'd10, 32'd0);
        step;
        wr_data = 32'hA1;
        step;
        CPU_RST = 1'b1;
        wr_valid = 1'b0;
        step;
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ctrl: got ready=%b busy=%b wr_ready=%b want 1 0 0", cmd_ready, busy, wr_ready); end
        total++; if (core_rst !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mid_reset_core: got core_rst=%b done=%b want 1 0", core_rst, done); end
        total++; if ({dram_we2, iram_we2} !== 8'd0 || dram_a2 !== 32'd0 || dram_wd2 !== 32'd0) begin bad++; $display("FAIL mid_reset_ports: got we=%h a2=%h wd2=%h want 0", {dram_we2, iram_we2}, dram_a2, dram_wd2); end
        CPU_RST = 1'b0;
        step;
        total++; if (dmem[0] !== 32'hA0 || dmem[1] !== 32'hA1) begin bad++; $display("FAIL mid_reset_kept: got %h %h want a0 a1", dmem[0], dmem[1]); end
    endtask

`ifdef DBG_ZERO_FILL_EN
    task automatic test_fill;
        int nw = 0, nd = 0, nz = 0;
        logic [31:0] last_a2 = 32'd0;
        logic hs;
        wr_valid = 1'b1;
        wr_data  = 32'h11;
        issue(2'd0, 1'b0, 13'd2, 32'd0);
        for (int cyc = 0; cyc < 4400 && nd == 0; cyc++) begin
            if (dram_we2 === 4'hF) begin
                if (nw < 2) begin
                    total++; if (dram_wd2 !== 32'h11 + 32'(nw)) begin bad++; $display("FAIL fill_stream[%0d]: got %h want %h", nw, dram_wd2, 32'h11 + 32'(nw)); end
                end else if (dram_wd2 !== 32'd0) nz++;
                last_a2 = dram_a2;
                nw++;
            end
            if (done === 1'b1) nd++;
            hs = wr_valid & wr_ready;
            step;
            if (hs) begin
                if (wr_data == 32'h11) wr_data = 32'h12;
                else wr_valid = 1'b0;
            end
        end
        total++; if (nw != 4096) begin bad++; $display("FAIL fill_count: got %0d want 4096", nw); end
        total++; if (last_a2 !== 32'h3FFC || nz != 0) begin bad++; $display("FAIL fill_tail: got a2=%h nonzero=%0d want 3ffc 0", last_a2, nz); end
        total++; if (nd != 1) begin bad++; $display("FAIL fill_done: got %0d want 1", nd); end
        step;
    endtask
`endif

    initial begin
        prog[0] = 32'h00100093;
        prog[1] = 32'h00200113;
        prog[2] = 32'h002081B3;
        test_reset;
        test_load;
        test_dump;
        test_run;
        test_len0_nop;
        test_clamp;
        test_reset_mid;
`ifdef DBG_ZERO_FILL_EN
        test_fill;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
